serial_divider_ctrl: RTL and testbench

Sequential controller for an unsigned restoring long-division machine. It accepts a dividend/divisor pair on a start handshake and performs one shift-and-trial-subtract iteration per clock. Each trial subtraction uses a single ripple subtractor of WIDTH+1 full-adder cells, computing A + ~B + 1. The block returns quotient, remainder and a divide-by-zero flag. It is the top-level sequencer of the long division machine and owns every register in the datapath.

---
 rtl/serial_divider_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_divider_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider_ctrl.sv
// serial_divider_ctrl: sequencer for an unsigned restoring long-division
// machine. One shift-and-trial-subtract iteration per clock through a
// WIDTH+1 cell ripple subtractor; returns quotient, remainder and a
// divide-by-zero flag. Owns every datapath register.
module serial_divider_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH:0]   r_q, r_d;        // partial remainder
  logic [WIDTH-1:0] q_q, q_d;        // dividend out / quotient in
  logic [WIDTH-1:0] d_q, d_d;        // latched divisor
  logic [CW-1:0]    cnt_q, cnt_d;    // iterations completed
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Ripple chain of full-adder cells computing a + b + 1.
  // Returns {carry_out, sum}.
  function automatic logic [WIDTH+1:0] ripple_add_cin1(
    input logic [WIDTH:0] a,
    input logic [WIDTH:0] b
  );
    logic [WIDTH+1:0] c;
    logic [WIDTH:0]   s;
    c    = '0;
    s    = '0;
    c[0] = 1'b1;
    for (int unsigned i = 0; i < WIDTH + 1; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[WIDTH + 1], s};
  endfunction

  logic [WIDTH:0]   trial_s;   // shifted partial remainder
  logic [WIDTH:0]   trial_t;   // trial difference
  logic             trial_c;   // carry-out: 1 means no borrow
  logic [WIDTH:0]   iter_r;
  logic [WIDTH-1:0] iter_q;

  // One restoring-division iteration on the current register contents.
  // The shifts drop R's MSB, which is always 0 since R < D after every step.
  always_comb begin
    trial_s = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};
    {trial_c, trial_t} = ripple_add_cin1(trial_s, ~{1'b0, d_q});
    iter_r  = trial_c ? trial_t : trial_s;
    iter_q  = (q_q << 1) | {{(WIDTH-1){1'b0}}, trial_c};
  end

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          r_d     = '0;
          q_d     = dividend;
          d_d     = divisor;
          cnt_d   = '0;
          quot_d  = '0;
          rem_d   = '0;
          dbz_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (d_q == '0) begin
          // Q still holds the untouched dividend on the first RUN edge.
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          r_d   = iter_r;
          q_d   = iter_q;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_ITER) begin
            quot_d  = iter_q;
            rem_d   = iter_r[WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_divider_ctrl.sv
// Self-checking bench for serial_divider_ctrl (WIDTH=8): directed vector
// table, hand-written multi-cycle sequences, and randomized operations
// checked against plain integer division.
module tb_serial_divider_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  serial_divider_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits (bounded) for done; n = edges waited, bn = busy samples seen.
  task automatic wait_done(output int n, output int bn);
    n  = 0;
    bn = 0;
    while (!done && n < 40) begin
      if (busy) bn++;
      cyc();
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez);
    int n, bn, lat;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    cyc();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_quot_clear", {24'd0, quotient}, 32'd0);
    wait_done(n, bn);
    lat = (b == 0) ? 1 : W;
    chk("latency", n, lat);
    chk("busy_cycles", bn, lat);
    chk("done_busy_low", {31'd0, busy}, 32'd0);
    chk("quotient", {24'd0, quotient}, {24'd0, eq});
    chk("remainder", {24'd0, remainder}, {24'd0, er});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, ez});
    cyc();
    chk("done_pulse_end", {31'd0, done}, 32'd0);
    chk("quotient_held", {24'd0, quotient}, {24'd0, eq});
    chk("remainder_held", {24'd0, remainder}, {24'd0, er});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_quot"}, {24'd0, quotient}, 32'd0);
    chk({tag, "_rem"}, {24'd0, remainder}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    int n, bn, n2, dones;
    logic [W-1:0] a, b, eq, er;

    vecs[0]  = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,  z: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  z: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  z: 1'b0};
    vecs[3]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  z: 1'b0};
    vecs[4]  = '{a: 8'd37,  b: 8'd0,   q: 8'hFF,  r: 8'd37, z: 1'b1};
    vecs[5]  = '{a: 8'd37,  b: 8'd5,   q: 8'd7,   r: 8'd2,  z: 1'b0};
    vecs[6]  = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  z: 1'b0};
    vecs[7]  = '{a: 8'd9,   b: 8'd4,   q: 8'd2,   r: 8'd1,  z: 1'b0};
    vecs[8]  = '{a: 8'd0,   b: 8'd0,   q: 8'hFF,  r: 8'd0,  z: 1'b1};
    vecs[9]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  z: 1'b0};
    vecs[10] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,  z: 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    cyc();
    cyc();
    chk_all_zero("reset");
    rst = 1'b0;
    cyc();

    for (int i = 0; i < 11; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);

    // start re-pulsed mid-operation must be ignored
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    cyc();
    start = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd1);
    wait_done(n, bn);
    chk("ignore_latency", n, 5);
    chk("ignore_quot", {24'd0, quotient}, 32'd14);
    chk("ignore_rem", {24'd0, remainder}, 32'd2);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done) dones++;
    end
    chk("ignore_no_second_done", dones, 0);

    // start held high: back-to-back operations
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    cyc();
    wait_done(n, bn);
    chk("b2b_latency1", n, W);
    chk("b2b_quot1", {24'd0, quotient}, 32'd8);
    chk("b2b_rem1", {24'd0, remainder}, 32'd2);
    cyc();
    chk("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
    chk("b2b_reaccept_done", {31'd0, done}, 32'd0);
    chk("b2b_reaccept_clear", {24'd0, quotient}, 32'd0);
    start = 1'b0;
    wait_done(n2, bn);
    chk("b2b_done_spacing", n2 + 1, W + 1);
    chk("b2b_quot2", {24'd0, quotient}, 32'd8);
    chk("b2b_rem2", {24'd0, remainder}, 32'd2);
    cyc();
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);

    // reset in the middle of an operation
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk_all_zero("midreset");
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (done || busy) dones++;
    end
    chk("midreset_no_done", dones, 0);
    run_op(8'd9, 8'd4, 8'd2, 8'd1, 1'b0);

    // randomized operations against integer division
    for (int i = 0; i < 150; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      if (b == 0) begin
        eq = 8'hFF;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op(a, b, eq, er, (b == 0));
      if ($urandom_range(0, 3) == 0) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
